// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the alignment rule used at request acceptance.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_LD_DATA = 3'd2,
    S_RMW_WR  = 3'd3,
    S_WR      = 3'd4,
    S_RESP    = 3'd5
  } lsu_state_t;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    if ((funct3 == F3_H) || (funct3 == F3_HU))
      bad = lane[0];
    else if (funct3 == F3_W)
      bad = (lane != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane handling for the load/store unit: extracts and extends load data
// from a memory word, and merges sub-word store data into a memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [31:0] shifted;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] mask;
  logic [31:0] ins;

  // Little-endian extract with sign/zero extension, and read-modify-write merge.
  always_comb begin
    byte_sh   = {lane, 3'b000};
    half_sh   = {lane[1], 4'b0000};
    shifted   = 32'd0;
    load_data = word;
    mask      = 32'd0;
    ins       = 32'd0;
    merged    = wdata;
    case (funct3)
      F3_B: begin
        shifted   = word >> byte_sh;
        load_data = {{24{shifted[7]}}, shifted[7:0]};
        mask      = 32'h0000_00FF << byte_sh;
        ins       = {24'd0, wdata[7:0]} << byte_sh;
        merged    = (word & ~mask) | ins;
      end
      F3_BU: begin
        shifted   = word >> byte_sh;
        load_data = {24'd0, shifted[7:0]};
      end
      F3_H: begin
        shifted   = word >> half_sh;
        load_data = {{16{shifted[15]}}, shifted[15:0]};
        mask      = 32'h0000_FFFF << half_sh;
        ins       = {16'd0, wdata[15:0]} << half_sh;
        merged    = (word & ~mask) | ins;
      end
      F3_HU: begin
        shifted   = word >> half_sh;
        load_data = {16'd0, shifted[15:0]};
      end
      default: begin
        load_data = word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-wide synchronous data memory
// without byte enables. Sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  lsu_state_t        state;
  logic [ADDR_W-1:0] lat_word;
  logic [1:0]        lat_lane;
  logic [31:0]       lat_wdata;
  logic [2:0]        lat_funct3;
  logic              lat_store;
  logic [31:0]       rdata_reg;
  logic              err_reg;

  logic              acc_store;
  logic              acc_load;
  logic              f3_ok;
  logic              acc_err;
  lsu_state_t        acc_next;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  // Address bits above the memory range wrap around and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  lsu_align u_align (
    .word      (mem_rd),
    .wdata     (lat_wdata),
    .funct3    (lat_funct3),
    .lane      (lat_lane),
    .load_data (load_data),
    .merged    (merged)
  );

  // Classify an incoming request and choose the state it enters on acceptance.
  always_comb begin
    acc_store = req_store;
    acc_load  = req_load & ~req_store;
    if (acc_store)
      f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    else
      f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
              (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
    acc_err = (acc_store | acc_load) &
              (~f3_ok | is_misaligned(req_funct3, req_addr[1:0]));
    if (acc_err || !(acc_store || acc_load))
      acc_next = S_RESP;
    else if (acc_store && (req_funct3 == F3_W))
      acc_next = S_WR;
    else
      acc_next = S_RD_ADDR;
  end

  // Sequencer: accept, memory access steps, single-cycle response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lat_word   <= '0;
      lat_lane   <= 2'd0;
      lat_wdata  <= 32'd0;
      lat_funct3 <= 3'd0;
      lat_store  <= 1'b0;
      rdata_reg  <= 32'd0;
      err_reg    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_word   <= req_addr[ADDR_W+1:2];
            lat_lane   <= req_addr[1:0];
            lat_wdata  <= req_wdata;
            lat_funct3 <= req_funct3;
            lat_store  <= acc_store;
            rdata_reg  <= 32'd0;
            err_reg    <= acc_err;
            state      <= acc_next;
          end
        end
        S_RD_ADDR: state <= lat_store ? S_RMW_WR : S_LD_DATA;
        S_LD_DATA: begin
          rdata_reg <= load_data;
          state     <= S_RESP;
        end
        S_RMW_WR:  state <= S_RESP;
        S_WR:      state <= S_RESP;
        S_RESP:    state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;
  assign mem_addr   = lat_word;
  assign mem_we     = ((state == S_WR) || (state == S_RMW_WR)) && !rst;
  assign mem_wd     = (state == S_WR) ? lat_wdata : merged;

endmodule
